// File: rtl/pc_ctrl_pkg.sv
// Shared types and defaults for the PC redirect controller.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    REDIR = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam int unsigned TIMEOUT_DEFAULT = 15;
  localparam int unsigned PC_W            = 16;

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Pipeline-facing signals of the PC redirect controller.
interface pc_redirect_ctrl_if;

  logic        ctrl_dec;
  logic        resolve_valid;
  logic        PC_src;
  logic        update_done;
  logic [15:0] PC_update;
  // Lets the redirect counter be seeded, e.g. to exercise the wrap point.
  logic        cnt_preload;
  logic [15:0] cnt_preload_val;

  logic        halt_fetch;
  logic        flush_ifid;
  logic        flush_idex;
  logic        pc_load;
  logic [15:0] pc_load_val;
  logic        busy;
  logic        timeout_err;
  logic [15:0] redirect_cnt;

  modport master (
    output ctrl_dec, resolve_valid, PC_src, update_done, PC_update,
           cnt_preload, cnt_preload_val,
    input  halt_fetch, flush_ifid, flush_idex, pc_load, pc_load_val,
           busy, timeout_err, redirect_cnt
  );

  modport slave (
    input  ctrl_dec, resolve_valid, PC_src, update_done, PC_update,
           cnt_preload, cnt_preload_val,
    output halt_fetch, flush_ifid, flush_idex, pc_load, pc_load_val,
           busy, timeout_err, redirect_cnt
  );

endinterface

// File: rtl/resolve_timer.sv
// Counts cycles spent waiting for a control-flow resolution and flags expiry.
module resolve_timer
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [3:0] LAST = 4'(TIMEOUT - 1);

  logic [3:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else if (clear) begin
      cnt_q <= 4'd0;
    end else if (enable) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch-redirect sequencer: stalls fetch on a decoded control instruction,
// waits for its resolution, then loads the new PC and flushes the front end.
//
//   state | meaning
//   RUN   | normal fetch; a decoded branch/call/ret starts a wait
//   WAIT  | fetch halted until resolve_valid or the timer expires
//   REDIR | load PC with the latched target, squash IF/ID
//   FLUSH | squash ID/EX, count the completed redirect
module pc_redirect_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  pc_redirect_ctrl_if.slave   bus
);

  state_t      state_q;
  state_t      state_d;
  logic [15:0] target_q;
  logic [15:0] cnt_q;
  logic        err_q;
  logic        latch_tgt;
  logic        set_err;
  logic        timer_clr;
  logic        timer_en;
  logic        timer_exp;

  assign timer_clr = (state_q == RUN) && bus.ctrl_dec;
  assign timer_en  = (state_q == WAIT);

  resolve_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clr),
    .enable  (timer_en),
    .expired (timer_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // A resolution arriving in the expiry cycle takes priority over the timeout.
  always_comb begin
    state_d   = state_q;
    latch_tgt = 1'b0;
    set_err   = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.ctrl_dec) state_d = WAIT;
      end
      WAIT: begin
        if (bus.resolve_valid) begin
          if (bus.PC_src && bus.update_done) begin
            latch_tgt = 1'b1;
            state_d   = REDIR;
          end else begin
            state_d = RUN;
          end
        end else if (timer_exp) begin
          set_err = 1'b1;
          state_d = RUN;
        end
      end
      REDIR:   state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q <= 16'h0000;
      cnt_q    <= 16'h0000;
      err_q    <= 1'b0;
    end else begin
      if (latch_tgt) target_q <= bus.PC_update;
      if (set_err)   err_q    <= 1'b1;
      if (bus.cnt_preload) begin
        cnt_q <= bus.cnt_preload_val;
      end else if (state_q == FLUSH) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  // Pulses decode straight from state so reset clears them without waiting for a clock.
  assign bus.halt_fetch   = (state_q != RUN) || bus.ctrl_dec;
  assign bus.busy         = (state_q != RUN);
  assign bus.pc_load      = (state_q == REDIR);
  assign bus.flush_ifid   = (state_q == REDIR);
  assign bus.flush_idex   = (state_q == FLUSH);
  assign bus.pc_load_val  = target_q;
  assign bus.timeout_err  = err_q;
  assign bus.redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: default-TIMEOUT instance plus a TIMEOUT=4 instance.
module tb_pc_redirect_ctrl;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  int   n_busy;
  int   n_load;

  pc_redirect_ctrl_if bus ();
  pc_redirect_ctrl_if bus4 ();

  pc_redirect_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pc_redirect_ctrl #(.TIMEOUT(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.ctrl_dec = 1'b0;      bus4.ctrl_dec = 1'b0;
    bus.resolve_valid = 1'b0; bus4.resolve_valid = 1'b0;
    bus.PC_src = 1'b0;        bus4.PC_src = 1'b0;
    bus.update_done = 1'b0;   bus4.update_done = 1'b0;
    bus.PC_update = 16'h0;    bus4.PC_update = 16'h0;
    bus.cnt_preload = 1'b0;   bus4.cnt_preload = 1'b0;
    bus.cnt_preload_val = 16'h0; bus4.cnt_preload_val = 16'h0;
  endtask

  // Drives one taken redirect on the default instance; ends in the cycle after FLUSH.
  task automatic run_taken(input logic [15:0] tgt);
    bus.ctrl_dec = 1'b1;
    tick;
    bus.ctrl_dec = 1'b0;
    bus.resolve_valid = 1'b1; bus.PC_src = 1'b1; bus.update_done = 1'b1;
    bus.PC_update = tgt;
    tick;
    clear_inputs;
    tick;
    tick;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    clear_inputs;
    rst = 1'b1;
    #12;
    check("rst_busy",        32'(bus.busy), 32'd0);
    check("rst_halt",        32'(bus.halt_fetch), 32'd0);
    check("rst_pc_load_val", 32'(bus.pc_load_val), 32'h0);
    check("rst_redirect_cnt", 32'(bus.redirect_cnt), 32'h0);
    check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    check("rst_pc_load",     32'(bus.pc_load), 32'd0);
    #1 rst = 1'b0;

    // Taken branch: decode in cycle 0, resolve in cycle 2
    tick;
    bus.ctrl_dec = 1'b1;
    #1;
    check("tk_c0_halt_comb", 32'(bus.halt_fetch), 32'd1);
    check("tk_c0_busy",      32'(bus.busy), 32'd0);
    tick;
    bus.ctrl_dec = 1'b0;
    #1;
    check("tk_c1_busy", 32'(bus.busy), 32'd1);
    check("tk_c1_halt", 32'(bus.halt_fetch), 32'd1);
    tick;
    bus.resolve_valid = 1'b1; bus.PC_src = 1'b1; bus.update_done = 1'b1;
    bus.PC_update = 16'h0123;
    #1;
    check("tk_c2_pc_load", 32'(bus.pc_load), 32'd0);
    tick;
    clear_inputs;
    #1;
    check("tk_c3_pc_load",     32'(bus.pc_load), 32'd1);
    check("tk_c3_flush_ifid",  32'(bus.flush_ifid), 32'd1);
    check("tk_c3_flush_idex",  32'(bus.flush_idex), 32'd0);
    check("tk_c3_pc_load_val", 32'(bus.pc_load_val), 32'h0123);
    tick;
    check("tk_c4_flush_idex", 32'(bus.flush_idex), 32'd1);
    check("tk_c4_pc_load",    32'(bus.pc_load), 32'd0);
    check("tk_c4_flush_ifid", 32'(bus.flush_ifid), 32'd0);
    tick;
    check("tk_c5_busy",         32'(bus.busy), 32'd0);
    check("tk_c5_flush_idex",   32'(bus.flush_idex), 32'd0);
    check("tk_c5_redirect_cnt", 32'(bus.redirect_cnt), 32'd1);

    // Not taken: resolve with PC_src=0
    bus.ctrl_dec = 1'b1;
    tick;
    bus.ctrl_dec = 1'b0;
    bus.resolve_valid = 1'b1; bus.PC_src = 1'b0; bus.update_done = 1'b1;
    bus.PC_update = 16'hDEAD;
    #1;
    check("nt_resolve_pc_load", 32'(bus.pc_load), 32'd0);
    tick;
    clear_inputs;
    #1;
    check("nt_busy",         32'(bus.busy), 32'd0);
    check("nt_pc_load",      32'(bus.pc_load), 32'd0);
    check("nt_flush_ifid",   32'(bus.flush_ifid), 32'd0);
    check("nt_flush_idex",   32'(bus.flush_idex), 32'd0);
    check("nt_redirect_cnt", 32'(bus.redirect_cnt), 32'd1);
    check("nt_pc_load_val",  32'(bus.pc_load_val), 32'h0123);

    // Inconsistent resolve: PC_src=1 but update_done=0
    bus.ctrl_dec = 1'b1;
    tick;
    bus.ctrl_dec = 1'b0;
    bus.resolve_valid = 1'b1; bus.PC_src = 1'b1; bus.update_done = 1'b0;
    bus.PC_update = 16'hBEEF;
    tick;
    clear_inputs;
    #1;
    check("inc_busy",        32'(bus.busy), 32'd0);
    check("inc_pc_load",     32'(bus.pc_load), 32'd0);
    check("inc_pc_load_val", 32'(bus.pc_load_val), 32'h0123);

    // Second ctrl_dec during WAIT must not start another wait
    bus.ctrl_dec = 1'b1;
    tick;
    n_load = 0;
    n_busy = 0;
    for (int i = 1; i <= 7; i++) begin
      clear_inputs;
      if (i == 1) bus.ctrl_dec = 1'b1;
      if (i == 2) begin
        bus.resolve_valid = 1'b1; bus.PC_src = 1'b1; bus.update_done = 1'b1;
        bus.PC_update = 16'h4567;
      end
      #1;
      if (bus.pc_load) n_load++;
      if (bus.busy) n_busy++;
      tick;
    end
    check("dbl_pc_load_count", 32'(n_load), 32'd1);
    check("dbl_busy_cycles",   32'(n_busy), 32'd4);
    check("dbl_redirect_cnt",  32'(bus.redirect_cnt), 32'd2);
    check("dbl_pc_load_val",   32'(bus.pc_load_val), 32'h4567);

    // Timeout at default TIMEOUT=15
    bus.ctrl_dec = 1'b1;
    tick;
    bus.ctrl_dec = 1'b0;
    n_load = 0;
    n_busy = 0;
    for (int i = 1; i <= 20; i++) begin
      #1;
      if (bus.pc_load) n_load++;
      if (bus.busy) n_busy++;
      if (i == 15) check("to15_err_before_exit", 32'(bus.timeout_err), 32'd0);
      tick;
    end
    check("to15_wait_cycles",  32'(n_busy), 32'd15);
    check("to15_pc_load",      32'(n_load), 32'd0);
    check("to15_timeout_err",  32'(bus.timeout_err), 32'd1);
    check("to15_busy",         32'(bus.busy), 32'd0);
    check("to15_redirect_cnt", 32'(bus.redirect_cnt), 32'd2);

    // timeout_err stays set across a later successful redirect
    run_taken(16'h0F0F);
    check("sticky_timeout_err", 32'(bus.timeout_err), 32'd1);
    check("sticky_redirect_cnt", 32'(bus.redirect_cnt), 32'd3);

    // TIMEOUT=4: resolution in the expiry cycle wins
    bus4.ctrl_dec = 1'b1;
    tick;
    bus4.ctrl_dec = 1'b0;
    tick;
    tick;
    tick;
    bus4.resolve_valid = 1'b1; bus4.PC_src = 1'b1; bus4.update_done = 1'b1;
    bus4.PC_update = 16'h0AAA;
    #1;
    check("t4_race_busy", 32'(bus4.busy), 32'd1);
    tick;
    clear_inputs;
    #1;
    check("t4_race_pc_load",     32'(bus4.pc_load), 32'd1);
    check("t4_race_pc_load_val", 32'(bus4.pc_load_val), 32'h0AAA);
    check("t4_race_timeout_err", 32'(bus4.timeout_err), 32'd0);
    tick;
    tick;

    // TIMEOUT=4: four WAIT cycles, then abandon
    bus4.ctrl_dec = 1'b1;
    tick;
    bus4.ctrl_dec = 1'b0;
    n_busy = 0;
    n_load = 0;
    for (int i = 1; i <= 8; i++) begin
      #1;
      if (bus4.busy) n_busy++;
      if (bus4.pc_load) n_load++;
      tick;
    end
    check("t4_wait_cycles", 32'(n_busy), 32'd4);
    check("t4_pc_load",     32'(n_load), 32'd0);
    check("t4_timeout_err", 32'(bus4.timeout_err), 32'd1);

    // Reset asserted in REDIR aborts the redirect
    bus.ctrl_dec = 1'b1;
    tick;
    bus.ctrl_dec = 1'b0;
    bus.resolve_valid = 1'b1; bus.PC_src = 1'b1; bus.update_done = 1'b1;
    bus.PC_update = 16'h7777;
    tick;
    clear_inputs;
    #1;
    check("rr_pre_pc_load", 32'(bus.pc_load), 32'd1);
    rst = 1'b1;
    #1;
    check("rr_pc_load",      32'(bus.pc_load), 32'd0);
    check("rr_flush_ifid",   32'(bus.flush_ifid), 32'd0);
    check("rr_busy",         32'(bus.busy), 32'd0);
    check("rr_pc_load_val",  32'(bus.pc_load_val), 32'h0);
    check("rr_redirect_cnt", 32'(bus.redirect_cnt), 32'h0);
    check("rr_timeout_err",  32'(bus.timeout_err), 32'd0);
    #2 rst = 1'b0;
    tick;
    check("rr_after_flush_idex", 32'(bus.flush_idex), 32'd0);
    check("rr_after_busy",       32'(bus.busy), 32'd0);

    // redirect_cnt wraps 0xFFFF -> 0x0000
    bus.cnt_preload = 1'b1;
    bus.cnt_preload_val = 16'hFFFF;
    tick;
    clear_inputs;
    check("wrap_preload", 32'(bus.redirect_cnt), 32'hFFFF);
    run_taken(16'h1234);
    check("wrap_redirect_cnt", 32'(bus.redirect_cnt), 32'h0000);
    check("wrap_pc_load_val",  32'(bus.pc_load_val), 32'h1234);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15, SHALL be the maximum number of cycles spent in WAIT before abandoning the wait (range 1..15).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 ctrl_dec  input  1  ID stage holds a branch, call or ret this cycle.
REQ-005 resolve_valid  input  1  control instruction outcome valid this cycle (branch/call in EX, ret at MEM/WB).
REQ-006 PC_src  input  1  PC update unit selects redirect.
REQ-007 update_done  input  1  PC update unit has a final target.
REQ-008 PC_update  input  16  redirect target from the PC update unit.
REQ-009 halt_fetch  output  1  freeze PC and IF/ID register.
REQ-010 flush_ifid  output  1  squash IF/ID contents.
REQ-011 flush_idex  output  1  squash ID/EX contents.
REQ-012 pc_load  output  1  load pc_load_val into PC this cycle.
REQ-013 pc_load_val  output  16  redirect target.
REQ-014 busy  output  1  state is not RUN.
REQ-015 timeout_err  output  1  sticky: a WAIT expired without resolution.
REQ-016 redirect_cnt  output  16  count of completed redirects.

Function
REQ-017 FSM states: RUN, WAIT, REDIR, FLUSH; one state per cycle, encoded as a 2-bit enum.
REQ-018 RUN: ctrl_dec=1 -> WAIT; otherwise stay. resolve_valid is ignored in RUN.
REQ-019 halt_fetch SHALL equal (state != RUN) OR (state == RUN AND ctrl_dec), combinationally, so fetch halts in the same cycle the control instruction is decoded.
REQ-020 WAIT: a 4-bit wait counter is cleared on entry and increments each WAIT cycle.
REQ-021 WAIT with resolve_valid=1, PC_src=1 and update_done=1: latch PC_update into the target register, then -> REDIR.
REQ-022 WAIT with resolve_valid=1 and (PC_src=0 or update_done=0): not taken, -> RUN; no pc_load, no flush.
REQ-023 WAIT with resolve_valid=0 and counter == TIMEOUT-1: set timeout_err, -> RUN with no redirect.
REQ-024 If resolve_valid arrives in the same cycle the counter expires, resolution SHALL win over timeout.
REQ-025 ctrl_dec SHALL be ignored in WAIT, REDIR and FLUSH.
REQ-026 REDIR: pc_load=1 and flush_ifid=1 for exactly one cycle; pc_load_val equals the latched target; -> FLUSH.
REQ-027 FLUSH: flush_idex=1 for exactly one cycle; redirect_cnt increments; -> RUN.
REQ-028 pc_load, flush_ifid and flush_idex SHALL be 0 in all other states. pc_load_val SHALL hold the last latched target at all times.
REQ-029 Latency: the taken-redirect path from the resolve cycle to pc_load is 1 cycle. The return to RUN from the resolve cycle is 3 cycles for taken and 1 cycle for not taken.
REQ-030 redirect_cnt wraps modulo 2^16 (0xFFFF -> 0x0000). The target is stored as 16-bit unsigned with no arithmetic.
REQ-031 busy = (state != RUN).

Reset
REQ-032 When rst=1, asynchronously: state=RUN, wait counter=0, target=0x0000, redirect_cnt=0x0000, timeout_err=0.
REQ-033 Reset in any state, including mid-REDIR, SHALL abort the redirect; the registered outputs pc_load, flush_ifid and flush_idex read 0 while rst=1.
REQ-034 timeout_err SHALL clear only on reset.

Structure
REQ-035 The state enum and the TIMEOUT default SHALL reside in the shared package pc_ctrl_pkg.
REQ-036 The wait counter with its expiry compare SHALL be the sub-module resolve_timer (clear, enable, expired ports); everything else is flat.

Verification
REQ-037 Taken branch: ctrl_dec at cycle 0; resolve_valid=PC_src=update_done=1 with PC_update=0x0123 at cycle 2 -> pc_load=1, pc_load_val=0x0123, flush_ifid=1 at cycle 3; flush_idex=1 at cycle 4; busy=0 at cycle 5; redirect_cnt=1.
REQ-038 Not-taken branch: ctrl_dec, then resolve_valid=1 with PC_src=0 -> no pc_load or flush; RUN the next cycle; redirect_cnt unchanged.
REQ-039 Timeout: ctrl_dec, no resolve_valid for 15 cycles -> timeout_err=1, back to RUN, no pc_load. With TIMEOUT=4, exit occurs after 4 WAIT cycles.
REQ-040 Inconsistent resolve (PC_src=1, update_done=0) -> treated as not taken. A second ctrl_dec during WAIT -> ignored, and a single redirect occurs.
REQ-041 Reset asserted in REDIR -> pc_load drops immediately, state=RUN, target=0x0000. redirect_cnt preloaded to 0xFFFF plus one redirect -> 0x0000.
